video_sig_gen: RTL and testbench
================================

Name: video_sig_gen

Overview:
- Raster timing generator directly upstream of the three tmds_encoder lanes.
- Produces pixel/line counters, active-draw enable, horizontal/vertical sync, a new-frame strobe and a frame counter from a single pixel clock.
- ad_out drives each encoder's ve_in; {vs_out, hs_out} drives the blue encoder's control_in.
- Defaults are 1280x720@60 (74.25 MHz pixel clock), positive sync polarity.

Parameters:
- ACTIVE_H, 1280, active pixels per line; must be divisible by 8.
- H_FRONT_PORCH, 110, pixels from end of active to hsync start.
- H_SYNC_WIDTH, 40, hsync pulse width in pixels.
- H_BACK_PORCH, 220, pixels from hsync end to line end (TOTAL_H = 1650).
- ACTIVE_V, 720, active lines per frame.
- V_FRONT_PORCH, 5, lines from end of active to vsync start.
- V_SYNC_WIDTH, 5, vsync pulse width in lines.
- V_BACK_PORCH, 20, lines from vsync end to frame end (TOTAL_V = 750).
- FPS, 60, frame counter modulus.

Ports:
- clk_in  input  1  pixel clock.
- rst_in  input  1  synchronous reset, active-high.
- hcount_out  output  $clog2(TOTAL_H)  (11 at defaults)  current pixel column.
- vcount_out  output  $clog2(TOTAL_V)  (10 at defaults)  current line.
- ad_out  output  1  active draw; feeds encoder ve_in.
- hs_out  output  1  horizontal sync, active-high.
- vs_out  output  1  vertical sync, active-high.
- nf_out  output  1  one-cycle new-frame strobe.
- fc_out  output  $clog2(FPS)  (6 at defaults)  frame count, 0..FPS-1.
- pattern_r_out, pattern_g_out, pattern_b_out  output  8 each  test-pattern colour (see Optional Feature).

Behaviour:
- Reset: on any clk_in edge with rst_in=1, all outputs take these values:
  - hcount_out=0, vcount_out=0, fc_out=0.
  - ad_out=0, hs_out=0, vs_out=0, nf_out=0.
  - All pattern outputs = 0.
  - Reset asserted mid-frame gives the same result on the next edge; no partial state survives.
- Counting: every edge with rst_in=0:
  - hcount increments.
  - At hcount=TOTAL_H-1, hcount wraps to 0 and vcount increments.
  - At vcount=TOTAL_V-1 together with hcount=TOTAL_H-1, both counters wrap to 0.
  - First edge after reset release: hcount_out=1, vcount_out=0.
- Registered, coherent decode: all flag outputs are registers computed from the next counter values, so they always describe the hcount_out/vcount_out presented in the same cycle. Zero latency between counters and flags.
  - ad_out=1 iff hcount_out<ACTIVE_H and vcount_out<ACTIVE_V. Exception: held 0 while in reset.
  - hs_out=1 iff ACTIVE_H+H_FRONT_PORCH <= hcount_out < ACTIVE_H+H_FRONT_PORCH+H_SYNC_WIDTH (1390..1429 at defaults). Independent of vcount.
  - vs_out=1 iff ACTIVE_V+V_FRONT_PORCH <= vcount_out < ACTIVE_V+V_FRONT_PORCH+V_SYNC_WIDTH (725..729). Asserted for entire lines, all hcount values.
  - nf_out=1 for exactly one cycle, when hcount_out=ACTIVE_H and vcount_out=ACTIVE_V (first blanking pixel after the last active line).
- Frame counter: fc_out increments on the same edge that nf_out rises; wraps from FPS-1 to 0.
- Frame length: exactly TOTAL_H*TOTAL_V cycles (1,237,500 at defaults); nf_out spacing is identical.
- Arithmetic: comparisons are unsigned at counter width; counters never exceed TOTAL-1.

Optional Feature:
- Macro: VIDEO_SIG_GEN_PATTERN_EN.
- Defined: pattern outputs are registered colour bars aligned with ad_out.
  - Bar index k = hcount_out / (ACTIVE_H/8), 160 pixels per bar at defaults.
  - r=255 for k in {0,1,4,5}; g=255 for k in {0,1,2,3}; b=255 for k in {0,2,4,6}; otherwise 0.
  - Sequence: white, yellow, cyan, green, magenta, red, blue, black.
  - All three outputs are 0 whenever ad_out=0.
- Undefined: pattern ports remain present and are tied to 0. No pattern logic is synthesised.

Test Plan:
1. Reset 5 cycles then release, run 2 cycles -> hcount_out 1 then 2, vcount_out=0, ad_out=1; all flags 0 during reset.
2. Run to line wrap -> hcount_out 1649 -> 0 with vcount_out 0 -> 1; ad_out falls at hcount_out=1280; hs_out high for exactly 40 cycles starting at hcount_out=1390.
3. Run one full frame -> nf_out pulses once at (1280,720); next pulse exactly 1,237,500 cycles later; vs_out high for 5*1650 = 8250 consecutive cycles starting at (0,725).
4. Run 61 frames -> fc_out counts 0..59, returns to 0 on the 60th nf_out, reads 1 after the 61st.
5. Assert rst_in at (700,400) with fc_out=7 -> next edge all outputs 0; after release counting restarts from (1,0) and fc_out=0.
6. With VIDEO_SIG_GEN_PATTERN_EN: at (0,0) RGB=255,255,255; (160,0) 255,255,0; (1279,10) 0,0,0; (800,0) 255,0,0; (1300,0) 0,0,0. Without the macro: RGB=0 everywhere.

Source files
------------

// File: rtl/video_sig_gen_if.sv
// -----------------------------------------------------------------------------
// video_sig_gen_if
//
// Purpose : bundles the raster timing outputs of video_sig_gen so that the
//           generator and its consumers (TMDS encoder lanes, pattern sinks)
//           share one connection.
//
// Parameters:
//   HCOUNT_W  width of hcount_out (clog2 of total pixels per line)
//   VCOUNT_W  width of vcount_out (clog2 of total lines per frame)
//   FC_W      width of fc_out     (clog2 of frame counter modulus)
//
// Signals (driven by the master = video_sig_gen):
//   hcount_out     current pixel column
//   vcount_out     current line
//   ad_out         active draw (encoder ve_in)
//   hs_out         horizontal sync, active-high
//   vs_out         vertical sync, active-high
//   nf_out         one-cycle new-frame strobe
//   fc_out         frame count
//   pattern_*_out  test-pattern colour, 8 bits per channel
//
// Modports:
//   master  generator side, drives every signal
//   slave   consumer side, reads every signal
// -----------------------------------------------------------------------------
interface video_sig_gen_if #(
   parameter int HCOUNT_W = 11,
   parameter int VCOUNT_W = 10,
   parameter int FC_W     = 6
);
   logic [HCOUNT_W-1:0] hcount_out;
   logic [VCOUNT_W-1:0] vcount_out;
   logic                ad_out;
   logic                hs_out;
   logic                vs_out;
   logic                nf_out;
   logic [FC_W-1:0]     fc_out;
   logic [7:0]          pattern_r_out;
   logic [7:0]          pattern_g_out;
   logic [7:0]          pattern_b_out;

   modport master (
      output hcount_out,
      output vcount_out,
      output ad_out,
      output hs_out,
      output vs_out,
      output nf_out,
      output fc_out,
      output pattern_r_out,
      output pattern_g_out,
      output pattern_b_out
   );

   modport slave (
      input hcount_out,
      input vcount_out,
      input ad_out,
      input hs_out,
      input vs_out,
      input nf_out,
      input fc_out,
      input pattern_r_out,
      input pattern_g_out,
      input pattern_b_out
   );
endinterface

// File: rtl/video_sig_gen.sv
// -----------------------------------------------------------------------------
// video_sig_gen
//
// Purpose : raster timing generator feeding the three TMDS encoder lanes.
//           Produces pixel/line counters, active-draw enable, positive-polarity
//           horizontal/vertical sync, a one-cycle new-frame strobe and a frame
//           counter. Defaults give 1280x720@60 at a 74.25 MHz pixel clock.
//
// Ports:
//   clk_in   pixel clock
//   rst_in   synchronous reset, active-high; every output reads 0 on the edge
//            that samples it high
//   vid      video_sig_gen_if.master carrying hcount/vcount, ad, hs, vs, nf,
//            fc and the pattern_r/g/b colour outputs
//
// Optional build macro:
//   VIDEO_SIG_GEN_PATTERN_EN  when defined, pattern outputs carry registered
//                             eight-bar colour bars aligned with ad_out; when
//                             undefined they are tied to 0.
//
// Every flag is a register loaded from the *next* counter values, so each
// flag always describes the hcount/vcount presented in the same cycle.
// -----------------------------------------------------------------------------
module video_sig_gen #(
   parameter int ACTIVE_H      = 1280,
   parameter int H_FRONT_PORCH = 110,
   parameter int H_SYNC_WIDTH  = 40,
   parameter int H_BACK_PORCH  = 220,
   parameter int ACTIVE_V      = 720,
   parameter int V_FRONT_PORCH = 5,
   parameter int V_SYNC_WIDTH  = 5,
   parameter int V_BACK_PORCH  = 20,
   parameter int FPS           = 60
) (
   input  logic           clk_in,
   input  logic           rst_in,
   video_sig_gen_if.master vid
);

   localparam int TOTAL_H = ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
   localparam int TOTAL_V = ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
   localparam int HW      = $clog2(TOTAL_H);
   localparam int VW      = $clog2(TOTAL_V);
   localparam int FW      = $clog2(FPS);

   // Decode boundaries held at counter width so every compare is unsigned at
   // the counter's own width. Ranges are expressed with inclusive upper
   // bounds so no constant ever needs to represent TOTAL itself.
   localparam logic [HW-1:0] H_LAST      = HW'(TOTAL_H - 1);
   localparam logic [VW-1:0] V_LAST      = VW'(TOTAL_V - 1);
   localparam logic [HW-1:0] H_ACT_LAST  = HW'(ACTIVE_H - 1);
   localparam logic [VW-1:0] V_ACT_LAST  = VW'(ACTIVE_V - 1);
   localparam logic [HW-1:0] H_NF        = HW'(ACTIVE_H);
   localparam logic [VW-1:0] V_NF        = VW'(ACTIVE_V);
   localparam logic [HW-1:0] HS_FIRST    = HW'(ACTIVE_H + H_FRONT_PORCH);
   localparam logic [HW-1:0] HS_LAST     = HW'(ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
   localparam logic [VW-1:0] VS_FIRST    = VW'(ACTIVE_V + V_FRONT_PORCH);
   localparam logic [VW-1:0] VS_LAST     = VW'(ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH - 1);
   localparam logic [FW-1:0] FC_LAST     = FW'(FPS - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [HW-1:0] hcount_reg, hcount_next;
   logic [VW-1:0] vcount_reg, vcount_next;
   logic [FW-1:0] fc_reg,     fc_next;
   logic          ad_reg,     ad_next;
   logic          hs_reg,     hs_next;
   logic          vs_reg,     vs_next;
   logic          nf_reg,     nf_next;

   // ---------------------------------------------------------------------
   // Next-state: counters first, then flags decoded from the next counters
   // ---------------------------------------------------------------------
   always_comb begin
      hcount_next = hcount_reg + 1'b1;
      vcount_next = vcount_reg;
      if (hcount_reg == H_LAST) begin
         hcount_next = '0;
         if (vcount_reg == V_LAST) begin
            vcount_next = '0;
         end else begin
            vcount_next = vcount_reg + 1'b1;
         end
      end

      ad_next = (hcount_next <= H_ACT_LAST) && (vcount_next <= V_ACT_LAST);
      hs_next = (hcount_next >= HS_FIRST) && (hcount_next <= HS_LAST);
      vs_next = (vcount_next >= VS_FIRST) && (vcount_next <= VS_LAST);
      nf_next = (hcount_next == H_NF) && (vcount_next == V_NF);

      // Frame counter steps on the same edge that raises nf.
      fc_next = fc_reg;
      if (nf_next) begin
         fc_next = (fc_reg == FC_LAST) ? '0 : fc_reg + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hcount_reg <= '0;
         vcount_reg <= '0;
         fc_reg     <= '0;
         ad_reg     <= 1'b0;
         hs_reg     <= 1'b0;
         vs_reg     <= 1'b0;
         nf_reg     <= 1'b0;
      end else begin
         hcount_reg <= hcount_next;
         vcount_reg <= vcount_next;
         fc_reg     <= fc_next;
         ad_reg     <= ad_next;
         hs_reg     <= hs_next;
         vs_reg     <= vs_next;
         nf_reg     <= nf_next;
      end
   end

   assign vid.hcount_out = hcount_reg;
   assign vid.vcount_out = vcount_reg;
   assign vid.fc_out     = fc_reg;
   assign vid.ad_out     = ad_reg;
   assign vid.hs_out     = hs_reg;
   assign vid.vs_out     = vs_reg;
   assign vid.nf_out     = nf_reg;

`ifdef VIDEO_SIG_GEN_PATTERN_EN
   // ---------------------------------------------------------------------
   // Colour bars: eight equal-width bars across the active line.
   // Bar membership is decoded with constant range compares rather than a
   // divide by the bar width, which is not a power of two at defaults.
   // ---------------------------------------------------------------------
   localparam int       BAR_W  = ACTIVE_H / 8;
   // One bit per bar, bar 0 in bit 0: which bars light each channel.
   localparam bit [7:0] R_BARS = 8'b0011_0011;
   localparam bit [7:0] G_BARS = 8'b0000_1111;
   localparam bit [7:0] B_BARS = 8'b0101_0101;

   logic [7:0] in_bar;
   logic [7:0] pat_r_reg, pat_r_next;
   logic [7:0] pat_g_reg, pat_g_next;
   logic [7:0] pat_b_reg, pat_b_next;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bar
         localparam logic [HW-1:0] BAR_LAST = HW'((gi + 1) * BAR_W - 1);
         if (gi == 0) begin : g_first
            assign in_bar[gi] = (hcount_next <= BAR_LAST);
         end else begin : g_rest
            localparam logic [HW-1:0] PREV_LAST = HW'(gi * BAR_W - 1);
            assign in_bar[gi] = (hcount_next <= BAR_LAST) && (hcount_next > PREV_LAST);
         end
      end
   endgenerate

   // Gated by ad_next so colour is 0 exactly when ad_out is 0.
   always_comb begin
      pat_r_next = {8{ad_next & (|(in_bar & R_BARS))}};
      pat_g_next = {8{ad_next & (|(in_bar & G_BARS))}};
      pat_b_next = {8{ad_next & (|(in_bar & B_BARS))}};
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pat_r_reg <= '0;
         pat_g_reg <= '0;
         pat_b_reg <= '0;
      end else begin
         pat_r_reg <= pat_r_next;
         pat_g_reg <= pat_g_next;
         pat_b_reg <= pat_b_next;
      end
   end

   assign vid.pattern_r_out = pat_r_reg;
   assign vid.pattern_g_out = pat_g_reg;
   assign vid.pattern_b_out = pat_b_reg;
`else
   assign vid.pattern_r_out = '0;
   assign vid.pattern_g_out = '0;
   assign vid.pattern_b_out = '0;
`endif

endmodule

// File: tb/tb_video_sig_gen.sv
// -----------------------------------------------------------------------------
// tb_video_sig_gen
//
// Self-checking bench for video_sig_gen using a reduced raster so whole
// frames are short: 32 active + 4 FP + 5 sync + 7 BP = 48 pixels/line,
// 8 active + 2 FP + 3 sync + 1 BP = 14 lines/frame, 672 cycles/frame,
// frame counter modulus 10. hsync at hcount 36..40, vsync on lines 10..12,
// nf at (32,8), colour bars 4 pixels wide.
// -----------------------------------------------------------------------------
module tb_video_sig_gen;

   localparam int AH = 32, HFP = 4, HSW = 5, HBP = 7;
   localparam int AV = 8,  VFP = 2, VSW = 3, VBP = 1;
   localparam int FPS   = 10;
   localparam int TH    = AH + HFP + HSW + HBP;   // 48
   localparam int TV    = AV + VFP + VSW + VBP;   // 14
   localparam int FRAME = TH * TV;                // 672
   localparam int HW    = $clog2(TH);
   localparam int VW    = $clog2(TV);
   localparam int FW    = $clog2(FPS);
`ifdef VIDEO_SIG_GEN_PATTERN_EN
   localparam bit PAT_EN = 1'b1;
`else
   localparam bit PAT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   video_sig_gen_if #(.HCOUNT_W(HW), .VCOUNT_W(VW), .FC_W(FW)) vid ();

   video_sig_gen #(
      .ACTIVE_H(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
      .ACTIVE_V(AV), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
      .FPS(FPS)
   ) dut (
      .clk_in(clk),
      .rst_in(rst),
      .vid(vid)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference raster position and frame count
   int exp_h = 0, exp_v = 0, exp_fc = 0;
   bit exp_rst = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Colour of the bar under pixel h: which 0=r 1=g 2=b
   function automatic int bar_colour(input int h, input int which);
      int k;
      k = h / (AH / 8);
      case (which)
         0:       return (k == 0 || k == 1 || k == 4 || k == 5) ? 255 : 0;
         1:       return (k <= 3) ? 255 : 0;
         default: return (k % 2 == 0) ? 255 : 0;
      endcase
   endfunction

   task automatic check_all();
      bit ad;
      ad = !exp_rst && (exp_h < AH) && (exp_v < AV);
      check("hcount", vid.hcount_out, exp_h);
      check("vcount", vid.vcount_out, exp_v);
      check("ad", vid.ad_out, ad);
      check("hs", vid.hs_out, (exp_h >= AH + HFP) && (exp_h < AH + HFP + HSW));
      check("vs", vid.vs_out, (exp_v >= AV + VFP) && (exp_v < AV + VFP + VSW));
      check("nf", vid.nf_out, !exp_rst && (exp_h == AH) && (exp_v == AV));
      check("fc", vid.fc_out, exp_fc);
      check("pat_r", vid.pattern_r_out, (PAT_EN && ad) ? bar_colour(exp_h, 0) : 0);
      check("pat_g", vid.pattern_g_out, (PAT_EN && ad) ? bar_colour(exp_h, 1) : 0);
      check("pat_b", vid.pattern_b_out, (PAT_EN && ad) ? bar_colour(exp_h, 2) : 0);
   endtask

   // One clock edge, then advance the reference and compare everything.
   task automatic cycle();
      bit r;
      r = rst;
      @(posedge clk);
      #1;
      if (r) begin
         exp_h = 0; exp_v = 0; exp_fc = 0; exp_rst = 1'b1;
      end else begin
         exp_rst = 1'b0;
         if (exp_h == TH - 1) begin
            exp_h = 0;
            exp_v = (exp_v == TV - 1) ? 0 : exp_v + 1;
         end else begin
            exp_h++;
         end
         if (exp_h == AH && exp_v == AV) exp_fc = (exp_fc + 1) % FPS;
      end
      check_all();
   endtask

   task automatic run_to(input int h, input int v, input string tag);
      int guard;
      guard = 0;
      while (!(exp_h == h && exp_v == v) && guard < 2 * FRAME) begin
         cycle();
         guard++;
      end
      check({tag, "_h"}, vid.hcount_out, h);
      check({tag, "_v"}, vid.vcount_out, v);
   endtask

   task automatic check_rgb(input string tag, input int r, input int g, input int b);
      check({tag, "_r"}, vid.pattern_r_out, PAT_EN ? r : 0);
      check({tag, "_g"}, vid.pattern_g_out, PAT_EN ? g : 0);
      check({tag, "_b"}, vid.pattern_b_out, PAT_EN ? b : 0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int hs_first, hs_len, guard, gap, nf_cnt, vs_len, vs_runs, vs_h, vs_v, n_nf;
      logic prev_vs;

      // 1. Reset for 5 cycles, then release
      rst = 1'b1;
      repeat (5) cycle();
      check("rst_h", vid.hcount_out, 0);
      check("rst_ad", vid.ad_out, 0);
      check("rst_hs", vid.hs_out, 0);
      check("rst_vs", vid.vs_out, 0);
      check("rst_nf", vid.nf_out, 0);
      rst = 1'b0;
      cycle();
      check("rel1_h", vid.hcount_out, 1);
      check("rel1_v", vid.vcount_out, 0);
      check("rel1_ad", vid.ad_out, 1);
      cycle();
      check("rel2_h", vid.hcount_out, 2);

      // 2. Active end, hsync pulse, line wrap
      run_to(31, 0, "act_last");
      check("act_last_ad", vid.ad_out, 1);
      cycle();
      check("blank_h", vid.hcount_out, 32);
      check("blank_ad", vid.ad_out, 0);
      hs_first = -1;
      hs_len = 0;
      while (exp_h != TH - 1) begin
         cycle();
         if (vid.hs_out) begin
            if (hs_first < 0) hs_first = int'(vid.hcount_out);
            hs_len++;
         end
      end
      check("hs_start", hs_first, 36);
      check("hs_len", hs_len, 5);
      check("line_end_h", vid.hcount_out, 47);
      cycle();
      check("wrap_h", vid.hcount_out, 0);
      check("wrap_v", vid.vcount_out, 1);

      // 3. New-frame strobe, frame length, vsync run
      guard = 0;
      while (!vid.nf_out && guard < 2 * FRAME) begin
         cycle();
         guard++;
      end
      check("nf1_h", vid.hcount_out, 32);
      check("nf1_v", vid.vcount_out, 8);
      check("nf1_fc", vid.fc_out, 1);
      gap = 0; nf_cnt = 0; vs_len = 0; vs_runs = 0; vs_h = -1; vs_v = -1;
      prev_vs = 1'b0;
      do begin
         cycle();
         gap++;
         if (vid.nf_out) nf_cnt++;
         if (vid.vs_out) begin
            if (!prev_vs) begin
               vs_runs++;
               if (vs_h < 0) begin
                  vs_h = int'(vid.hcount_out);
                  vs_v = int'(vid.vcount_out);
               end
            end
            vs_len++;
         end
         prev_vs = vid.vs_out;
      end while (!vid.nf_out && gap < 2 * FRAME);
      check("nf_gap", gap, 672);
      check("nf_cnt", nf_cnt, 1);
      check("vs_len", vs_len, 144);
      check("vs_runs", vs_runs, 1);
      check("vs_start_h", vs_h, 0);
      check("vs_start_v", vs_v, 10);
      check("nf2_fc", vid.fc_out, 2);
      cycle();
      check("nf_one_cycle", vid.nf_out, 0);

      // 4. Frame counter wraps at FPS
      n_nf = 2;
      guard = 0;
      while (n_nf < FPS + 1 && guard < (FPS + 1) * FRAME) begin
         cycle();
         guard++;
         if (vid.nf_out) begin
            n_nf++;
            check("fc_at_nf", vid.fc_out, n_nf % FPS);
            if (n_nf == FPS) check("fc_wrap0", vid.fc_out, 0);
         end
      end
      check("nf_total", n_nf, FPS + 1);
      check("fc_after_wrap", vid.fc_out, 1);

      // 5. Reset mid-frame at (20,5) with fc=7
      guard = 0;
      while (!(exp_fc == 7 && exp_h == 20 && exp_v == 5) && guard < (FPS + 1) * FRAME) begin
         cycle();
         guard++;
      end
      check("pre_rst_h", vid.hcount_out, 20);
      check("pre_rst_v", vid.vcount_out, 5);
      check("pre_rst_fc", vid.fc_out, 7);
      check("pre_rst_ad", vid.ad_out, 1);
      rst = 1'b1;
      cycle();
      check("mid_rst_h", vid.hcount_out, 0);
      check("mid_rst_v", vid.vcount_out, 0);
      check("mid_rst_fc", vid.fc_out, 0);
      check("mid_rst_ad", vid.ad_out, 0);
      check("mid_rst_r", vid.pattern_r_out, 0);
      rst = 1'b0;
      cycle();
      check("restart_h", vid.hcount_out, 1);
      check("restart_v", vid.vcount_out, 0);
      check("restart_fc", vid.fc_out, 0);

      // 6. Colour bars (all 0 when the pattern is not built)
      run_to(4, 0, "pat_yellow");
      check_rgb("pat_yellow", 255, 255, 0);
      run_to(8, 0, "pat_cyan");
      check_rgb("pat_cyan", 0, 255, 255);
      run_to(20, 0, "pat_red");
      check_rgb("pat_red", 255, 0, 0);
      run_to(36, 0, "pat_blank");
      check_rgb("pat_blank", 0, 0, 0);
      run_to(31, 3, "pat_black");
      check_rgb("pat_black", 0, 0, 0);
      run_to(0, 0, "pat_white");
      check_rgb("pat_white", 255, 255, 255);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
